// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding from EX/MEM and MEM/WB.
// Holds the decoded instruction for one cycle, resolves ALU operands
// combinationally against the two later stages, and counts inserted bubbles.
module id_ex_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [DATA_WIDTH-1:0] id_rs_data,
   input  logic [DATA_WIDTH-1:0] id_rt_data,
   input  logic [DATA_WIDTH-1:0] id_imm,
   input  logic [REG_ADDR_W-1:0] id_rs_addr,
   input  logic [REG_ADDR_W-1:0] id_rt_addr,
   input  logic [REG_ADDR_W-1:0] id_rd_addr,
   input  logic [3:0]            id_alu_ctrl,
   input  logic                  id_use_imm,
   input  logic                  id_reg_write,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  exmem_reg_write,
   input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
   input  logic [DATA_WIDTH-1:0] exmem_result,
   input  logic                  memwb_reg_write,
   input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
   input  logic [DATA_WIDTH-1:0] memwb_result,
   output logic [DATA_WIDTH-1:0] rega,
   output logic [DATA_WIDTH-1:0] regb,
   output logic [3:0]            control,
   output logic                  ex_valid,
   output logic                  ex_reg_write,
   output logic [REG_ADDR_W-1:0] ex_rd_addr,
   output logic [15:0]           bubble_cnt
);

   logic                  valid_q;
   logic                  reg_write_q;
   logic [REG_ADDR_W-1:0] rd_addr_q;
   logic [REG_ADDR_W-1:0] rs_addr_q;
   logic [REG_ADDR_W-1:0] rt_addr_q;
   logic [3:0]            ctrl_q;
   logic [DATA_WIDTH-1:0] rs_data_q;
   logic [DATA_WIDTH-1:0] rt_data_q;
   logic [DATA_WIDTH-1:0] imm_q;
   logic                  use_imm_q;
   logic [15:0]           bubble_cnt_q;

   logic [DATA_WIDTH-1:0] fwd_rs;
   logic [DATA_WIDTH-1:0] fwd_rt;
   logic                  load_bubble;

   // A bubble enters the stage on a flush, or when an empty slot advances.
   assign load_bubble = flush || (!stall && !id_valid);

   // Operand forwarding: the younger EX/MEM result wins over MEM/WB, and
   // register 0 is hard-wired so it is never forwarded.
   always_comb begin
      fwd_rs = rs_data_q;
      if (exmem_reg_write && (exmem_rd_addr == rs_addr_q) && (rs_addr_q != '0))
         fwd_rs = exmem_result;
      else if (memwb_reg_write && (memwb_rd_addr == rs_addr_q) && (rs_addr_q != '0))
         fwd_rs = memwb_result;

      fwd_rt = rt_data_q;
      if (exmem_reg_write && (exmem_rd_addr == rt_addr_q) && (rt_addr_q != '0))
         fwd_rt = exmem_result;
      else if (memwb_reg_write && (memwb_rd_addr == rt_addr_q) && (rt_addr_q != '0))
         fwd_rt = memwb_result;
   end

   // Pipeline register: reset clears, flush loads a bubble, stall holds the
   // instruction but re-captures forwarded operands so a retiring producer
   // is not lost, otherwise the decoded instruction advances.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         rd_addr_q   <= '0;
         rs_addr_q   <= '0;
         rt_addr_q   <= '0;
         ctrl_q      <= '0;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         imm_q       <= '0;
         use_imm_q   <= 1'b0;
      end else if (flush) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         rd_addr_q   <= '0;
         rs_addr_q   <= '0;
         rt_addr_q   <= '0;
         ctrl_q      <= '0;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         imm_q       <= '0;
         use_imm_q   <= 1'b0;
      end else if (stall) begin
         rs_data_q   <= fwd_rs;
         rt_data_q   <= fwd_rt;
      end else begin
         valid_q     <= id_valid;
         reg_write_q <= id_reg_write;
         rd_addr_q   <= id_rd_addr;
         rs_addr_q   <= id_rs_addr;
         rt_addr_q   <= id_rt_addr;
         ctrl_q      <= id_alu_ctrl;
         rs_data_q   <= id_rs_data;
         rt_data_q   <= id_rt_data;
         imm_q       <= id_imm;
         use_imm_q   <= id_use_imm;
      end
   end

   // Saturating count of bubble cycles inserted into the stage.
   always_ff @(posedge clk) begin
      if (!rst_n)
         bubble_cnt_q <= '0;
      else if (load_bubble && (bubble_cnt_q != 16'hFFFF))
         bubble_cnt_q <= bubble_cnt_q + 16'd1;
   end

   assign rega         = fwd_rs;
   assign regb         = use_imm_q ? imm_q : fwd_rt;
   assign control      = ctrl_q;
   assign ex_valid     = valid_q;
   assign ex_reg_write = reg_write_q && valid_q;
   assign ex_rd_addr   = rd_addr_q;
   assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: pass-through, immediate select,
// forwarding priority, register-0 handling, stall capture, flush and reset.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
   logic [3:0]  id_alu_ctrl;
   logic        id_use_imm, id_reg_write;
   logic        stall, flush;
   logic        exmem_reg_write, memwb_reg_write;
   logic [4:0]  exmem_rd_addr, memwb_rd_addr;
   logic [31:0] exmem_result, memwb_result;
   logic [31:0] rega, regb;
   logic [3:0]  control;
   logic        ex_valid, ex_reg_write;
   logic [4:0]  ex_rd_addr;
   logic [15:0] bubble_cnt;

   int compared   = 0;
   int mismatched = 0;

   id_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
      .id_alu_ctrl(id_alu_ctrl), .id_use_imm(id_use_imm), .id_reg_write(id_reg_write),
      .stall(stall), .flush(flush),
      .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr),
      .exmem_result(exmem_result),
      .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr),
      .memwb_result(memwb_result),
      .rega(rega), .regb(regb), .control(control), .ex_valid(ex_valid),
      .ex_reg_write(ex_reg_write), .ex_rd_addr(ex_rd_addr), .bubble_cnt(bubble_cnt)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] rs_d, input logic [31:0] rt_d,
                                input logic [31:0] imm, input logic [4:0] rs_a,
                                input logic [4:0] rt_a, input logic [4:0] rd_a,
                                input logic [3:0] ctrl, input logic use_imm, input logic rw);
      id_valid     = v;
      id_rs_data   = rs_d;
      id_rt_data   = rt_d;
      id_imm       = imm;
      id_rs_addr   = rs_a;
      id_rt_addr   = rt_a;
      id_rd_addr   = rd_a;
      id_alu_ctrl  = ctrl;
      id_use_imm   = use_imm;
      id_reg_write = rw;
   endtask

   task automatic clearForwarding();
      exmem_reg_write = 1'b0; exmem_rd_addr = '0; exmem_result = '0;
      memwb_reg_write = 1'b0; memwb_rd_addr = '0; memwb_result = '0;
   endtask

   initial begin
      // Reset with everything idle
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 4'h0, 1'b0, 1'b0);
      clearForwarding();
      tick(); tick();
      checkOutput("rst_ex_valid", 32'(ex_valid), 0);
      checkOutput("rst_ex_reg_write", 32'(ex_reg_write), 0);
      checkOutput("rst_ex_rd_addr", 32'(ex_rd_addr), 0);
      checkOutput("rst_control", 32'(control), 0);
      checkOutput("rst_bubble_cnt", 32'(bubble_cnt), 0);
      checkOutput("rst_rega", rega, 0);
      checkOutput("rst_regb", regb, 0);

      // Pass-through, one-cycle latency
      rst_n = 1'b1;
      applyStimulus(1'b1, 32'd10, 32'd20, 32'h0, 5'd1, 5'd2, 5'd3, 4'h0, 1'b0, 1'b1);
      tick();
      checkOutput("pass_rega", rega, 32'd10);
      checkOutput("pass_regb", regb, 32'd20);
      checkOutput("pass_control", 32'(control), 0);
      checkOutput("pass_ex_valid", 32'(ex_valid), 1);
      checkOutput("pass_ex_reg_write", 32'(ex_reg_write), 1);
      checkOutput("pass_ex_rd_addr", 32'(ex_rd_addr), 3);
      checkOutput("pass_bubble_cnt", 32'(bubble_cnt), 0);

      // Immediate selects regb; opcode passes through unchanged
      applyStimulus(1'b1, 32'd1, 32'd2, 32'h55, 5'd5, 5'd6, 5'd7, 4'hA, 1'b1, 1'b0);
      tick();
      checkOutput("imm_regb", regb, 32'h55);
      checkOutput("imm_control", 32'(control), 32'hA);
      checkOutput("imm_ex_reg_write", 32'(ex_reg_write), 0);
      // Immediate is never forwarded even when rt matches
      exmem_reg_write = 1'b1; exmem_rd_addr = 5'd6; exmem_result = 32'h999;
      #1;
      checkOutput("imm_no_fwd_regb", regb, 32'h55);
      clearForwarding();

      // Forwarding priority on rs, then rt forwarding
      applyStimulus(1'b1, 32'h1, 32'h66, 32'h0, 5'd4, 5'd6, 5'd8, 4'h3, 1'b0, 1'b1);
      tick();
      exmem_reg_write = 1'b1; exmem_rd_addr = 5'd4; exmem_result = 32'h111;
      memwb_reg_write = 1'b1; memwb_rd_addr = 5'd4; memwb_result = 32'h222;
      #1;
      checkOutput("fwd_both_rega", rega, 32'h111);
      exmem_reg_write = 1'b0;
      #1;
      checkOutput("fwd_memwb_rega", rega, 32'h222);
      memwb_reg_write = 1'b0;
      #1;
      checkOutput("fwd_none_rega", rega, 32'h1);
      exmem_reg_write = 1'b1; exmem_rd_addr = 5'd6; exmem_result = 32'h333;
      #1;
      checkOutput("fwd_exmem_regb", regb, 32'h333);
      checkOutput("fwd_rt_only_rega", rega, 32'h1);
      clearForwarding();

      // Register 0 is never forwarded
      applyStimulus(1'b1, 32'd5, 32'd0, 32'h0, 5'd0, 5'd0, 5'd1, 4'h0, 1'b0, 1'b1);
      tick();
      exmem_reg_write = 1'b1; exmem_rd_addr = 5'd0; exmem_result = 32'd9;
      memwb_reg_write = 1'b1; memwb_rd_addr = 5'd0; memwb_result = 32'd11;
      #1;
      checkOutput("r0_rega", rega, 32'd5);
      checkOutput("r0_regb", regb, 32'd0);
      clearForwarding();

      // Stall captures a MEM/WB result that retires during the stall
      applyStimulus(1'b1, 32'h0, 32'h1234, 32'h0, 5'd0, 5'd7, 5'd8, 4'h2, 1'b0, 1'b1);
      tick();
      stall = 1'b1;
      applyStimulus(1'b1, 32'hDEAD, 32'hFFFF, 32'h0, 5'd9, 5'd9, 5'd9, 4'hF, 1'b0, 1'b1);
      memwb_reg_write = 1'b1; memwb_rd_addr = 5'd7; memwb_result = 32'hABCD;
      #1;
      checkOutput("stall_fwd_regb", regb, 32'hABCD);
      tick();
      clearForwarding();
      #1;
      checkOutput("stall1_regb", regb, 32'hABCD);
      checkOutput("stall1_control", 32'(control), 32'h2);
      checkOutput("stall1_ex_rd_addr", 32'(ex_rd_addr), 32'd8);
      tick();
      checkOutput("stall2_regb", regb, 32'hABCD);
      tick();
      checkOutput("stall3_regb", regb, 32'hABCD);
      checkOutput("stall_bubble_cnt", 32'(bubble_cnt), 0);

      // Flush wins over stall
      flush = 1'b1;
      tick();
      checkOutput("flush_ex_valid", 32'(ex_valid), 0);
      checkOutput("flush_ex_reg_write", 32'(ex_reg_write), 0);
      checkOutput("flush_control", 32'(control), 0);
      checkOutput("flush_ex_rd_addr", 32'(ex_rd_addr), 0);
      checkOutput("flush_regb", regb, 0);
      checkOutput("flush_bubble_cnt", 32'(bubble_cnt), 1);

      // Invalid instruction advancing counts as a bubble; reg_write gated by valid
      flush = 1'b0; stall = 1'b0;
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5, 4'h1, 1'b0, 1'b1);
      tick();
      checkOutput("inv_bubble_cnt", 32'(bubble_cnt), 2);
      checkOutput("inv_ex_reg_write", 32'(ex_reg_write), 0);
      checkOutput("inv_ex_rd_addr", 32'(ex_rd_addr), 5);

      // Reset asserted while a valid instruction is held by a stall
      applyStimulus(1'b1, 32'h77, 32'h88, 32'h0, 5'd3, 5'd2, 5'd9, 4'h7, 1'b0, 1'b1);
      tick();
      checkOutput("pre_rst_ex_valid", 32'(ex_valid), 1);
      stall = 1'b1;
      tick();
      checkOutput("held_control", 32'(control), 32'h7);
      checkOutput("held_bubble_cnt", 32'(bubble_cnt), 2);
      rst_n = 1'b0;
      tick();
      checkOutput("mid_rst_ex_valid", 32'(ex_valid), 0);
      checkOutput("mid_rst_ex_reg_write", 32'(ex_reg_write), 0);
      checkOutput("mid_rst_ex_rd_addr", 32'(ex_rd_addr), 0);
      checkOutput("mid_rst_control", 32'(control), 0);
      checkOutput("mid_rst_bubble_cnt", 32'(bubble_cnt), 0);
      checkOutput("mid_rst_rega", rega, 0);
      checkOutput("mid_rst_regb", regb, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of operand and result buses.
REQ-002 Parameter: REG_ADDR_W, 5, width of register-file addresses.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-005 id_valid  input  1  decode stage presents a valid instruction.
REQ-006 id_rs_data, id_rt_data  input  DATA_WIDTH each  register-file read data.
REQ-007 id_imm  input  DATA_WIDTH  sign/zero-extended immediate from decode.
REQ-008 id_rs_addr, id_rt_addr, id_rd_addr  input  REG_ADDR_W each  source and destination register numbers.
REQ-009 id_alu_ctrl  input  4  ALU opcode, 0 = ADD through 15 = SOME, passed unmodified.
REQ-010 id_use_imm  input  1  regb takes immediate instead of rt.
REQ-011 id_reg_write  input  1  instruction writes rd.
REQ-012 stall  input  1  hold stage contents.
REQ-013 flush  input  1  replace stage contents with a bubble.
REQ-014 exmem_reg_write, exmem_rd_addr, exmem_result  input  1 / REG_ADDR_W / DATA_WIDTH  EX/MEM forwarding source.
REQ-015 memwb_reg_write, memwb_rd_addr, memwb_result  input  1 / REG_ADDR_W / DATA_WIDTH  MEM/WB forwarding source.
REQ-016 rega, regb  output  DATA_WIDTH each  ALU operands, forwarding resolved.
REQ-017 control  output  4  ALU opcode.
REQ-018 ex_valid, ex_reg_write, ex_rd_addr  output  1 / 1 / REG_ADDR_W  executing-instruction status.
REQ-019 bubble_cnt  output  16  count of bubble cycles inserted.

Function
REQ-020 On rising edge with rst_n=1, flush=0, stall=0: register all id_* inputs; latency from id_* to rega/regb/control is exactly one cycle.
REQ-021 flush=1 (regardless of stall): load bubble -- valid 0, reg_write 0, rd_addr 0, ctrl 0 (ADD), rs/rt/imm data 0, use_imm 0, rs/rt addr 0.
REQ-022 stall=1, flush=0: hold all registered fields, except rs/rt data registers SHALL load the currently forwarded operand values, so that a forwarding source retiring during the stall is not lost.
REQ-023 rega forwarding, evaluated combinationally from registered fields: if exmem_reg_write=1, exmem_rd_addr=rs_addr and rs_addr!=0, rega=exmem_result; else if the same holds for memwb, rega=memwb_result; else rega=registered rs data.
REQ-024 EX/MEM SHALL take priority over MEM/WB when both match.
REQ-025 Register 0 SHALL never be forwarded; rs_addr=0 yields registered rs data.
REQ-026 regb: registered imm if registered use_imm=1 (no forwarding); else rt forwarded by rules REQ-023..REQ-025 using rt_addr.
REQ-027 ex_reg_write SHALL equal registered reg_write AND registered valid.
REQ-028 bubble_cnt SHALL increment by 1 on each edge where a bubble is loaded (flush=1, or stall=0 with id_valid=0), saturating at 16'hFFFF; it SHALL not change while stall=1 and flush=0.
REQ-029 control SHALL equal registered ctrl with no re-encoding.

Reset
REQ-030 rst_n=0 at an edge SHALL override flush and stall and clear all registered fields to 0: ex_valid=0, ex_reg_write=0, ex_rd_addr=0, control=0, bubble_cnt=0; rega/regb then equal 0 unless a forwarding source matches a nonzero address (none can, since addresses are 0).
REQ-031 Reset asserted mid-stall SHALL discard the held instruction.

Verification
REQ-032 Pass-through: id_rs_data=10, id_rt_data=20, id_alu_ctrl=0, addresses 1/2/3, no forwarding -> next cycle rega=10, regb=20, control=0, ex_valid=1.
REQ-033 Forwarding priority: registered rs_addr=4, exmem_rd_addr=4 result=0x111, memwb_rd_addr=4 result=0x222, both write=1 -> rega=0x111; drop exmem_reg_write -> rega=0x222.
REQ-034 Register 0: rs_addr=0, rs data=5, exmem_rd_addr=0 write=1 result=9 -> rega=5.
REQ-035 Stall capture: rt_addr=7, memwb_rd_addr=7 result=0xABCD for one cycle with stall=1, then memwb idle, stall=1 two more cycles -> regb stays 0xABCD throughout.
REQ-036 Flush over stall: stall=1 and flush=1 same edge -> ex_valid=0, ex_reg_write=0, control=0, bubble_cnt +1.
REQ-037 Reset mid-stall: stall=1 with valid instruction held, rst_n=0 one edge -> all outputs 0, bubble_cnt=0.
